// File: rtl/mdsa_shear_sort_ctrl.sv
// Shear-sort sequencer for an 8x8 matrix: loads rows, time-shares one external
// 8-lane sorter over 7 snake-ordered row/column phases, then drains row-major ascending.
module mdsa_shear_sort_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int SORT_LAT   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*DATA_WIDTH-1:0] in_data,
   output logic                    srt_en,
   output logic                    srt_dir,
   output logic [8*DATA_WIDTH-1:0] srt_data_in,
   input  logic [8*DATA_WIDTH-1:0] srt_data_out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*DATA_WIDTH-1:0] out_data,
   output logic                    busy,
   output logic                    done
);

   localparam int         RW       = 8 * DATA_WIDTH;
   localparam logic [3:0] LAT_LAST = 4'(SORT_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t                state_r, state_s;
   logic [2:0]            row_r, row_s;
   logic [2:0]            vec_r, vec_s;
   logic [2:0]            phase_r, phase_s;
   logic [3:0]            lat_r, lat_s;
   logic [DATA_WIDTH-1:0] m_r [8][8];
   logic [DATA_WIDTH-1:0] m_s [8][8];

   logic [RW-1:0]         issue_vec_s;
   logic [RW-1:0]         out_row_s;
   logic                  issue_dir_s;
   logic                  done_s;

   logic                  srt_en_r;
   logic                  srt_dir_r;
   logic                  done_r;
   logic [RW-1:0]         srt_data_in_r;
   logic [RW-1:0]         out_data_r;

   assign srt_en      = srt_en_r;
   assign srt_dir     = srt_dir_r;
   assign srt_data_in = srt_data_in_r;
   assign out_data    = out_data_r;
   assign done        = done_r;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state, counters and next matrix contents (row load or sorter write-back).
   always_comb begin
      state_s = state_r;
      row_s   = row_r;
      vec_s   = vec_r;
      phase_s = phase_r;
      lat_s   = lat_r;
      m_s     = m_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_s = S_LOAD;
               row_s   = 3'd0;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               for (int c = 0; c < 8; c++) begin
                  m_s[row_r][3'(c)] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
               end
               row_s = row_r + 3'd1;
               if (row_r == 3'd7) begin
                  state_s = S_ISSUE;
                  phase_s = 3'd0;
                  vec_s   = 3'd0;
               end else begin
                  state_s = S_LOAD;
               end
            end else begin
               state_s = S_LOAD;
            end
         end
         S_ISSUE: begin
            state_s = S_WAIT;
            lat_s   = 4'd0;
         end
         S_WAIT: begin
            if (lat_r == LAT_LAST) begin
               // Odd phases sort columns, even phases sort rows.
               for (int i = 0; i < 8; i++) begin
                  if (phase_r[0]) begin
                     m_s[3'(i)][vec_r] = srt_data_out[i*DATA_WIDTH +: DATA_WIDTH];
                  end else begin
                     m_s[vec_r][3'(i)] = srt_data_out[i*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
               if (vec_r == 3'd7) begin
                  vec_s = 3'd0;
                  if (phase_r == 3'd6) begin
                     state_s = S_DRAIN;
                     row_s   = 3'd0;
                  end else begin
                     phase_s = phase_r + 3'd1;
                     state_s = S_ISSUE;
                  end
               end else begin
                  vec_s   = vec_r + 3'd1;
                  state_s = S_ISSUE;
               end
            end else begin
               lat_s = lat_r + 4'd1;
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               row_s = row_r + 3'd1;
               if (row_r == 3'd7) begin
                  state_s = S_IDLE;
               end else begin
                  state_s = S_DRAIN;
               end
            end else begin
               state_s = S_DRAIN;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State-decoded handshakes and next values of the registered outputs.
   always_comb begin
      in_ready    = (state_r == S_LOAD);
      out_valid   = (state_r == S_DRAIN);
      busy        = (state_r != S_IDLE);
      done_s      = (state_r == S_DRAIN) && out_ready && (row_r == 3'd7);
      issue_dir_s = phase_s[0] ? 1'b0 : vec_s[0];
      issue_vec_s = '0;
      out_row_s   = '0;
      // Odd rows leave the last row phase descending, so they are reversed on the way out.
      for (int i = 0; i < 8; i++) begin
         issue_vec_s[i*DATA_WIDTH +: DATA_WIDTH] =
            phase_s[0] ? m_s[3'(i)][vec_s] : m_s[vec_s][3'(i)];
         out_row_s[i*DATA_WIDTH +: DATA_WIDTH] =
            row_s[0] ? m_s[row_s][3'(7 - i)] : m_s[row_s][3'(i)];
      end
   end

   // Counters and matrix storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_r   <= 3'd0;
         vec_r   <= 3'd0;
         phase_r <= 3'd0;
         lat_r   <= 4'd0;
         for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
               m_r[r][c] <= '0;
            end
         end
      end else begin
         row_r   <= row_s;
         vec_r   <= vec_s;
         phase_r <= phase_s;
         lat_r   <= lat_s;
         m_r     <= m_s;
      end
   end

   // Registered sorter controls, output row and done pulse, loaded one cycle ahead of use.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         srt_en_r      <= 1'b0;
         srt_dir_r     <= 1'b0;
         srt_data_in_r <= '0;
         out_data_r    <= '0;
         done_r        <= 1'b0;
      end else begin
         srt_en_r <= (state_s == S_ISSUE);
         done_r   <= done_s;
         if (state_s == S_ISSUE) begin
            srt_data_in_r <= issue_vec_s;
            srt_dir_r     <= issue_dir_s;
         end
         if (state_s == S_DRAIN) begin
            out_data_r <= out_row_s;
         end
      end
   end

endmodule

// File: tb/tb_mdsa_shear_sort_ctrl.sv
// Scoreboard bench: two controllers (SORT_LAT 1 and 3) share stimulus, each with a
// behavioural sorter; expected rows come from sorting all 64 loaded values.
module tb_mdsa_shear_sort_ctrl;

   localparam int DW = 16;
   localparam int RW = 8 * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, in_valid, out_ready;
   logic [RW-1:0] in_data;
   logic          in_ready [2], srt_en [2], srt_dir [2], out_valid [2], busy [2], done [2];
   logic [RW-1:0] srt_din [2], srt_dout [2], out_data [2];

   int            checks = 0, errors = 0;
   int            cyc = 0;
   int            acc_cyc = 0;
   bit            hold_off = 1'b0;
   logic [RW-1:0] exp_q [2][$];

   always #5 clk = ~clk;

   always_ff @(posedge clk) cyc <= cyc + 1;

   task automatic chk_vec(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] sort8(input logic [RW-1:0] v, input logic desc);
      logic [DW-1:0] a [8];
      logic [DW-1:0] t;
      logic [RW-1:0] r;
      for (int i = 0; i < 8; i++) a[i] = v[i*DW +: DW];
      for (int i = 1; i < 8; i++) begin
         for (int j = i; j > 0; j--) begin
            if (desc ? (a[j-1] < a[j]) : (a[j-1] > a[j])) begin
               t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end else begin
               break;
            end
         end
      end
      for (int i = 0; i < 8; i++) r[i*DW +: DW] = a[i];
      return r;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [RW-1:0] pipe [LAT];

      mdsa_shear_sort_ctrl #(.DATA_WIDTH(DW), .SORT_LAT(LAT)) dut (
         .clk(clk), .rst(rst), .start(start),
         .in_valid(in_valid), .in_ready(in_ready[g]), .in_data(in_data),
         .srt_en(srt_en[g]), .srt_dir(srt_dir[g]),
         .srt_data_in(srt_din[g]), .srt_data_out(srt_dout[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready), .out_data(out_data[g]),
         .busy(busy[g]), .done(done[g])
      );

      // Behavioural sorter: result of an en cycle appears LAT cycles later.
      always_ff @(posedge clk) begin
         if (srt_en[g]) pipe[0] <= sort8(srt_din[g], srt_dir[g]);
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign srt_dout[g] = pipe[LAT-1];

      // Monitor: pops expected rows, checks stalls, done, sorter pacing and latency.
      initial begin
         logic [RW-1:0] held, expv;
         bit stalled = 1'b0, exp_done = 1'b0, prev_ov = 1'b0;
         int rows_seen = 0, last_en = -1, en_cnt = 0;
         forever begin
            @(negedge clk);
            if (rst) begin
               stalled = 1'b0; exp_done = 1'b0; prev_ov = 1'b0;
               rows_seen = 0; last_en = -1; en_cnt = 0;
            end else begin
               if (stalled) begin
                  chk_int($sformatf("stall_valid%0d", g), int'(out_valid[g]), 1);
                  chk_vec($sformatf("stall_data%0d", g), out_data[g], held);
               end
               if (done[g] || exp_done) chk_int($sformatf("done%0d", g), int'(done[g]), int'(exp_done));
               if (exp_done) chk_int($sformatf("idle_after_done%0d", g), int'(busy[g]), 0);
               exp_done = 1'b0;
               if (in_ready[g]) begin
                  last_en = -1; en_cnt = 0;
               end
               if (srt_en[g]) begin
                  if (last_en >= 0) chk_int($sformatf("en_gap%0d", g), cyc - last_en, LAT + 1);
                  last_en = cyc;
                  en_cnt++;
               end
               if (out_valid[g] && !prev_ov) begin
                  chk_int($sformatf("en_count%0d", g), en_cnt, 56);
                  chk_int($sformatf("latency%0d", g), cyc - acc_cyc, 56 * (LAT + 1) + 1);
               end
               prev_ov = out_valid[g];
               stalled = out_valid[g] && !out_ready;
               held    = out_data[g];
               if (out_valid[g] && out_ready) begin
                  if (exp_q[g].size() == 0) begin
                     chk_int($sformatf("unexpected_row%0d", g), 1, 0);
                  end else begin
                     expv = exp_q[g].pop_front();
                     chk_vec($sformatf("row%0d_dut%0d", rows_seen, g), out_data[g], expv);
                  end
                  rows_seen++;
                  if (rows_seen == 8) begin
                     exp_done = 1'b1; rows_seen = 0;
                  end
               end
            end
         end
      end
   end

   // Sink readiness: random, forced low while hold_off is set.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         out_ready = hold_off ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   task automatic check_zero(input string tag);
      for (int g = 0; g < 2; g++) begin
         chk_int({tag, "_in_ready"}, int'(in_ready[g]), 0);
         chk_int({tag, "_out_valid"}, int'(out_valid[g]), 0);
         chk_int({tag, "_busy"}, int'(busy[g]), 0);
         chk_int({tag, "_done"}, int'(done[g]), 0);
         chk_int({tag, "_srt_en"}, int'(srt_en[g]), 0);
         chk_int({tag, "_srt_dir"}, int'(srt_dir[g]), 0);
         chk_vec({tag, "_srt_data_in"}, srt_din[g], '0);
         chk_vec({tag, "_out_data"}, out_data[g], '0);
      end
   endtask

   task automatic run_job(input int mode, input bit do_ign, input bit do_hold, input bit do_rst);
      logic [DW-1:0] mat [8][8];
      logic [DW-1:0] vals [$];
      logic [RW-1:0] row, d0;
      int t;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            case (mode)
               0:       mat[r][c] = DW'(63 - (8 * r + c));
               1:       mat[r][c] = DW'(5);
               2:       mat[r][c] = DW'($urandom);
               default: mat[r][c] = DW'($urandom_range(0, 7));
            endcase
         end
      end
      if (mode == 1) begin
         mat[7][7] = '0;
         mat[0][0] = DW'(9);
      end
      vals = {};
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) vals.push_back(mat[r][c]);
      vals.sort();
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) row[c*DW +: DW] = vals[8 * r + c];
         exp_q[0].push_back(row);
         exp_q[1].push_back(row);
      end

      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk_int("in_ready_after_start0", int'(in_ready[0]), 1);
      chk_int("in_ready_after_start1", int'(in_ready[1]), 1);
      for (int r = 0; r < 8; r++) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         for (int c = 0; c < 8; c++) row[c*DW +: DW] = mat[r][c];
         in_data  = row;
         in_valid = 1'b1;
         if (r == 7) acc_cyc = cyc;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;

      if (do_ign) begin
         repeat (40) begin @(posedge clk); #1; end
         chk_int("in_ready_sorting0", int'(in_ready[0]), 0);
         chk_int("in_ready_sorting1", int'(in_ready[1]), 0);
         start = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1 start = 1'b0; in_valid = 1'b0;
      end

      if (do_rst) begin
         repeat ($urandom_range(50, 58)) @(posedge clk);
         #3 rst = 1'b1;
         #1 check_zero("midjob_rst");
         exp_q[0].delete();
         exp_q[1].delete();
         @(posedge clk); #3 rst = 1'b0;
         @(posedge clk); #1;
         chk_int("busy_after_rst0", int'(busy[0]), 0);
         chk_int("busy_after_rst1", int'(busy[1]), 0);
         return;
      end

      if (do_hold) begin
         t = 0;
         while (!out_valid[0] && t < 1000) begin @(posedge clk); #1; t++; end
         chk_int("drain_reached", int'(t < 1000), 1);
         hold_off = 1'b1;
         @(posedge clk); #2 d0 = out_data[0];
         repeat (8) begin @(posedge clk); #2; end
         chk_vec("hold_data", out_data[0], d0);
         chk_int("hold_valid", int'(out_valid[0]), 1);
         hold_off = 1'b0;
      end

      t = 0;
      while ((busy[0] || busy[1]) && t < 3000) begin @(posedge clk); #1; t++; end
      chk_int("job_complete", int'(t < 3000), 1);
      @(negedge clk);
      @(negedge clk);
      chk_int("rows_left0", exp_q[0].size(), 0);
      chk_int("rows_left1", exp_q[1].size(), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #2 check_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      chk_int("busy_idle0", int'(busy[0]), 0);
      chk_int("busy_idle1", int'(busy[1]), 0);

      run_job(0, 1'b0, 1'b0, 1'b0);   // reversed 63..0
      run_job(1, 1'b0, 1'b0, 1'b0);   // duplicates with one min and one max
      run_job(2, 1'b1, 1'b1, 1'b0);   // random, ignored pulses, 10-cycle backpressure
      run_job(3, 1'b0, 1'b0, 1'b1);   // abandoned by reset mid-sort
      run_job(2, 1'b0, 1'b0, 1'b0);   // fresh job after reset
      run_job(3, 1'b1, 1'b1, 1'b0);   // heavy duplicates

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdsa_shear_sort_ctrl.md
# mdsa_shear_sort_ctrl

Sequencing controller that runs a full 8×8 multidimensional (shear) sort by time-sharing one 8-input bitonic index merge sorter. It accepts an 8×8 matrix row by row, then drives the sorter through alternating row and column phases with snake-order direction control. It streams the fully sorted matrix out in row-major ascending order. It sits between the MDSA data source/sink and the single sorter instance, and owns that sorter's `en`, `dir` and `data_in` inputs.

## Interface
- `DATA_WIDTH`, default 32: width of one element.
- `SORT_LAT`, default 1: cycles from the sorter `en` cycle to a valid `data_out`. Legal range is 1..15.
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high. All state clears immediately.
- `start` input, 1 bit: begin a load/sort/drain job. Sampled only in IDLE.
- `in_valid` input, 1 bit: an input row is present.
- `in_ready` output, 1 bit: controller accepts an input row.
- `in_data` input, 8*DATA_WIDTH bits: one matrix row. Lane i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- `srt_en` output, 1 bit: sorter load strobe.
- `srt_dir` output, 1 bit: sorter direction. 0 means ascending (lane 0 smallest); 1 means descending.
- `srt_data_in` output, 8*DATA_WIDTH bits: vector sent to the sorter.
- `srt_data_out` input, 8*DATA_WIDTH bits: sorted vector returned by the sorter.
- `out_valid` output, 1 bit: an output row is valid.
- `out_ready` input, 1 bit: the sink accepts the output row.
- `out_data` output, 8*DATA_WIDTH bits: one output row.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse when the last output row is accepted.

## Operation
- Storage: an internal 8×8 register matrix M[r][c].
- States: IDLE → LOAD → ISSUE → WAIT → (ISSUE | DRAIN) → IDLE.
- IDLE: `start`=1 → LOAD, with the row counter cleared.
- LOAD:
  - `in_ready`=1.
  - Each beat with `in_valid`&&`in_ready` writes `in_data` to M[row] and increments row.
  - Acceptance of row 7 → ISSUE, with phase=0 and vec=0.
- Phases: 0..6.
  - Even phase = row phase. The vector is M[vec][*], and `srt_dir`=vec[0] (even rows ascending, odd rows descending).
  - Odd phase = column phase. The vector is lane i = M[i][vec], and `srt_dir`=0.
- ISSUE: for one cycle, `srt_en`=1, `srt_data_in`=the vector, and `srt_dir` as above. Then → WAIT.
- WAIT:
  - Counts SORT_LAT cycles.
  - On the last WAIT cycle, `srt_data_out` is written back to the same row or column.
  - Then vec increments. When vec wraps 7→0, phase increments.
  - After phase 6, vec 7 → DRAIN. Otherwise → ISSUE.
- DRAIN:
  - `out_valid`=1.
  - `out_data` = M[k], lane-reversed when k is odd, so the concatenated stream is ascending.
  - k advances on `out_valid`&&`out_ready`.
  - Acceptance of row 7 → `done`=1 for the next cycle, and the state returns to IDLE that same cycle.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `start` outside IDLE is ignored.
- `in_valid` outside LOAD is ignored.
- Duplicate keys are legal. Their output order among equals is unspecified, but the values must be correct.

## Timing
- Reset values: `in_ready`, `out_valid`, `busy`, `done`, `srt_en`, `srt_dir` = 0; `srt_data_in`, `out_data` = 0; M = 0; state = IDLE.
- All outputs are registered, except `in_ready`, `out_valid` and `busy`, which decode state directly.
- `start` sampled high → LOAD on the next cycle, so `in_ready`=1 one cycle after `start`.
- Each vector takes SORT_LAT+1 cycles. Sort time = 56*(SORT_LAT+1) cycles, which is 112 at SORT_LAT=1.
- First `out_valid` occurs on the cycle after the final write-back.
- `srt_data_in` holds the last issued vector when `srt_en`=0.
- Reset asserted mid-job: the job is abandoned, all outputs drop to reset values asynchronously, and no `done` is generated.

## Test plan
- Reset check: assert `rst` with random prior state → all outputs 0 in the same cycle; `busy`=0 after release.
- Reverse input at SORT_LAT=1: load row r, lane c = 63-(8r+c); pulse `start` → output row r, lane c = 8r+c; `done` pulses once after row 7.
- Latency at SORT_LAT=1 and SORT_LAT=3: `out_valid` rises exactly 113 and 225 cycles, respectively, after row 7 is accepted. Each `srt_en` pulse is followed by SORT_LAT low cycles.
- Duplicates: 62 elements of value 5, one 0 at M[7][7], one 9 at M[0][0] → output row 0 lane 0 = 0, row 7 lane 7 = 9, all other elements 5.
- Backpressure and ignored inputs: hold `out_ready`=0 for 10 cycles during DRAIN → `out_data` is unchanged and k is unchanged. Pulse `start` and `in_valid` during a phase → no effect.
- Mid-job reset: assert `rst` during phase 3 → `busy`=0 and `srt_en`=0 immediately. A fresh job then completes with the correct results.
